// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and state type for pipeline stage registers
package pipe_pkg;

  localparam logic [31:0] MIPS_NOP     = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// rtl/pipe_skid_entry.sv - single storage slot (valid, pc, npc, data) for the skid path
module pipe_skid_entry #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [PC_W-1:0]   i_npc,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [PC_W-1:0]   o_pc,
  output logic [PC_W-1:0]   o_npc,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_npc;
  logic [DATA_W-1:0] r_data;

  // Clear wins so a flush discards an entry even if a load were requested.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_npc   <= '0;
      r_data  <= '0;
    end else begin
      if (i_clear) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
      end
      if (i_load) begin
        r_pc   <= i_pc;
        r_npc  <= i_npc;
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_npc   = r_npc;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall, flush/NOP injection,
// valid/ready handshake, optional skid entry and saturating stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(RESET_VECTOR),
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(MIPS_NOP),
  parameter bit                SKID     = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [PC_W-1:0]   in_npc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_npc,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [PC_W-1:0]   r_out_pc;
  logic [PC_W-1:0]   r_out_npc;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_out_fire;
  logic              w_in_fire;
  logic              w_load_in;
  logic              w_load_from_skid;
  logic              w_skid_load;
  logic              w_skid_clear;
  logic              w_skid_valid;
  logic [PC_W-1:0]   w_skid_pc;
  logic [PC_W-1:0]   w_skid_npc;
  logic [DATA_W-1:0] w_skid_data;

  assign out_valid  = (r_state != EMPTY);
  assign w_out_fire = out_valid & out_ready & ~stall;
  // With the skid slot, in_ready depends only on flops plus the flush term.
  assign in_ready   = ~flush & (SKID ? ~w_skid_valid : (~out_valid | w_out_fire));
  assign w_in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_load_in        = 1'b0;
    w_load_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;
    if (flush) begin
      w_state_nxt  = EMPTY;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = FULL;
            w_load_in   = 1'b1;
          end
        end
        FULL: begin
          if (w_in_fire && w_out_fire) begin
            w_load_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = SKIDDED;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = EMPTY;
          end
        end
        SKIDDED: begin
          if (w_out_fire) begin
            w_state_nxt      = FULL;
            w_load_from_skid = 1'b1;
            w_skid_clear     = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // A bubble only replaces the payload; pc/npc keep the last real entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_pc   <= RESET_PC;
      r_out_npc  <= RESET_PC;
      r_out_data <= NOP_WORD;
    end else if (flush) begin
      r_out_data <= NOP_WORD;
    end else if (w_load_in) begin
      r_out_pc   <= in_pc;
      r_out_npc  <= in_npc;
      r_out_data <= in_data;
    end else if (w_load_from_skid) begin
      r_out_pc   <= w_skid_pc;
      r_out_npc  <= w_skid_npc;
      r_out_data <= w_skid_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (stall && out_valid && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  generate
    if (SKID) begin : g_skid
      pipe_skid_entry #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W)
      ) u_skid (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (in_pc),
        .i_npc   (in_npc),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_npc   (w_skid_npc),
        .o_data  (w_skid_data)
      );
    end else begin : g_no_skid
      assign w_skid_valid = 1'b0;
      assign w_skid_pc    = '0;
      assign w_skid_npc   = '0;
      assign w_skid_data  = '0;
    end
  endgenerate

  assign out_pc    = r_out_pc;
  assign out_npc   = r_out_npc;
  assign out_data  = r_out_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table-driven bench for pipe_stage_reg (skid and no-skid builds)
module tb_pipe_stage_reg;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  int   n_checks;
  int   n_errors;

  // Instance A: default parameters (SKID=1, CNT_W=16)
  logic        a_reset_n, a_in_valid, a_in_ready, a_stall, a_flush, a_out_valid, a_out_ready;
  logic [31:0] a_in_pc, a_in_npc, a_in_data, a_out_pc, a_out_npc, a_out_data;
  logic [15:0] a_stall_cnt;

  // Instance B: SKID=0, narrow counter, non-zero reset PC and NOP word
  logic        b_reset_n, b_in_valid, b_in_ready, b_stall, b_flush, b_out_valid, b_out_ready;
  logic [31:0] b_in_pc, b_in_npc, b_in_data, b_out_pc, b_out_npc, b_out_data;
  logic [3:0]  b_stall_cnt;

  pipe_stage_reg u_dut_a (
    .clk       (clk),
    .reset_n   (a_reset_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_pc     (a_in_pc),
    .in_npc    (a_in_npc),
    .in_data   (a_in_data),
    .stall     (a_stall),
    .flush     (a_flush),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_pc    (a_out_pc),
    .out_npc   (a_out_npc),
    .out_data  (a_out_data),
    .stall_cnt (a_stall_cnt)
  );

  pipe_stage_reg #(
    .RESET_PC (32'h0000_0100),
    .NOP_WORD (32'hDEAD_BEEF),
    .SKID     (1'b0),
    .CNT_W    (4)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (b_reset_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_pc     (b_in_pc),
    .in_npc    (b_in_npc),
    .in_data   (b_in_data),
    .stall     (b_stall),
    .flush     (b_flush),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_pc    (b_out_pc),
    .out_npc   (b_out_npc),
    .out_data  (b_out_data),
    .stall_cnt (b_stall_cnt)
  );

  typedef struct {
    logic        vi;
    logic [31:0] pc;
    logic [31:0] data;
    logic        st;
    logic        fl;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_npc;
    logic [31:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    //          vi pc            data          st fl ordy | ir ov pc            npc           data          cnt
    vecs[0]  = '{H, 32'h00, 32'hA000_0000, L, L, H,  H, H, 32'h00, 32'h04, 32'hA000_0000, 16'd0};
    vecs[1]  = '{H, 32'h04, 32'hA000_0004, L, L, H,  H, H, 32'h04, 32'h08, 32'hA000_0004, 16'd0};
    vecs[2]  = '{H, 32'h08, 32'hA000_0008, L, L, H,  H, H, 32'h08, 32'h0C, 32'hA000_0008, 16'd0};
    vecs[3]  = '{L, 32'h0C, 32'hA000_000C, L, L, H,  H, L, 32'h08, 32'h0C, 32'hA000_0008, 16'd0};
    vecs[4]  = '{H, 32'h10, 32'hA000_0010, L, L, L,  H, H, 32'h10, 32'h14, 32'hA000_0010, 16'd0};
    vecs[5]  = '{H, 32'h14, 32'hA000_0014, H, L, H,  H, H, 32'h10, 32'h14, 32'hA000_0010, 16'd1};
    vecs[6]  = '{H, 32'h18, 32'hA000_0018, H, L, H,  L, H, 32'h10, 32'h14, 32'hA000_0010, 16'd2};
    vecs[7]  = '{H, 32'h18, 32'hA000_0018, H, L, H,  L, H, 32'h10, 32'h14, 32'hA000_0010, 16'd3};
    vecs[8]  = '{H, 32'h18, 32'hA000_0018, L, L, H,  L, H, 32'h14, 32'h18, 32'hA000_0014, 16'd3};
    vecs[9]  = '{H, 32'h18, 32'hA000_0018, L, L, H,  H, H, 32'h18, 32'h1C, 32'hA000_0018, 16'd3};
    vecs[10] = '{H, 32'h1C, 32'hA000_001C, L, L, L,  H, H, 32'h18, 32'h1C, 32'hA000_0018, 16'd3};
    vecs[11] = '{H, 32'h20, 32'hA000_0020, H, H, H,  L, L, 32'h18, 32'h1C, 32'h0000_0000, 16'd4};
    vecs[12] = '{H, 32'h20, 32'hA000_0020, L, L, H,  H, H, 32'h20, 32'h24, 32'hA000_0020, 16'd4};
    vecs[13] = '{L, 32'h24, 32'hA000_0024, L, L, H,  H, L, 32'h20, 32'h24, 32'hA000_0020, 16'd4};

    a_reset_n = 1'b0; a_in_valid = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_pc = '0; a_in_npc = '0; a_in_data = '0;
    b_reset_n = 1'b0; b_in_valid = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_pc = '0; b_in_npc = '0; b_in_data = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("a_rst out_valid", 32'(a_out_valid), 32'h0);
    chk("a_rst out_pc",    a_out_pc,         32'h0);
    chk("a_rst out_npc",   a_out_npc,        32'h0);
    chk("a_rst out_data",  a_out_data,       32'h0);
    chk("a_rst stall_cnt", 32'(a_stall_cnt), 32'h0);
    chk("b_rst out_pc",    b_out_pc,         32'h100);
    chk("b_rst out_data",  b_out_data,       32'hDEAD_BEEF);
    @(negedge clk);
    a_reset_n = 1'b1;
    b_reset_n = 1'b1;
    #1;
    chk("a_rst in_ready", 32'(a_in_ready), 32'h1);
    chk("b_rst in_ready", 32'(b_in_ready), 32'h1);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a_in_valid  = vecs[i].vi;
      a_in_pc     = vecs[i].pc;
      a_in_npc    = vecs[i].pc + 32'h4;
      a_in_data   = vecs[i].data;
      a_stall     = vecs[i].st;
      a_flush     = vecs[i].fl;
      a_out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(a_in_ready), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d out_pc", i),    a_out_pc,         vecs[i].e_pc);
      chk($sformatf("v%0d out_npc", i),   a_out_npc,        vecs[i].e_npc);
      chk($sformatf("v%0d out_data", i),  a_out_data,       vecs[i].e_data);
      chk($sformatf("v%0d stall_cnt", i), 32'(a_stall_cnt), 32'(vecs[i].e_cnt));
    end

    // SKID=0 backpressure: in_ready follows out_ready combinationally
    @(negedge clk);
    b_in_valid = 1'b1; b_in_pc = 32'h40; b_in_npc = 32'h44; b_in_data = 32'hB000_0040;
    b_out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("b_load out_valid", 32'(b_out_valid), 32'h1);
    chk("b_load out_pc",    b_out_pc,         32'h40);
    @(negedge clk);
    b_in_pc = 32'h44; b_in_npc = 32'h48; b_in_data = 32'hB000_0044;
    #1;
    chk("b_bp in_ready low", 32'(b_in_ready), 32'h0);
    b_out_ready = 1'b1;
    #1;
    chk("b_bp in_ready high", 32'(b_in_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("b_bp out_pc",   b_out_pc,   32'h44);
    chk("b_bp out_data", b_out_data, 32'hB000_0044);

    // Counter saturation on the 4-bit build
    @(negedge clk);
    b_in_valid = 1'b0;
    b_stall    = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("b_sat cnt15",     32'(b_stall_cnt), 32'hF);
    chk("b_sat hold pc",   b_out_pc,         32'h44);
    @(posedge clk);
    #1;
    chk("b_sat no wrap",   32'(b_stall_cnt), 32'hF);
    chk("b_sat out_valid", 32'(b_out_valid), 32'h1);

    // Flush beats stall; pc holds, payload becomes the NOP word
    @(negedge clk);
    b_flush    = 1'b1;
    b_in_valid = 1'b1;
    #1;
    chk("b_flush in_ready", 32'(b_in_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("b_flush out_valid", 32'(b_out_valid), 32'h0);
    chk("b_flush out_data",  b_out_data,       32'hDEAD_BEEF);
    chk("b_flush out_pc",    b_out_pc,         32'h44);

    @(negedge clk);
    b_flush = 1'b0; b_stall = 1'b0;
    b_in_pc = 32'h48; b_in_npc = 32'h4C; b_in_data = 32'hB000_0048;
    @(posedge clk);
    #1;
    chk("b_reload out_pc", b_out_pc,         32'h48);
    chk("b_reload cnt",    32'(b_stall_cnt), 32'hF);

    // Asynchronous reset between edges
    @(negedge clk);
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    #2;
    b_reset_n = 1'b0;
    #1;
    chk("b_arst out_valid", 32'(b_out_valid), 32'h0);
    chk("b_arst stall_cnt", 32'(b_stall_cnt), 32'h0);
    chk("b_arst out_pc",    b_out_pc,         32'h100);
    chk("b_arst out_data",  b_out_data,       32'hDEAD_BEEF);
    @(negedge clk);
    b_reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("b_post out_valid", 32'(b_out_valid), 32'h0);
    chk("b_post in_ready",  32'(b_in_ready),  32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the MIPS pipeline core, replacing the fixed fetch/decode register and reusable at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries PC, next-PC and a payload word, tracks a valid bit, and supports hazard-unit stall, branch flush with NOP injection, and a valid/ready handshake. An optional skid entry keeps `in_ready` registered for timing. A saturating stall counter is included for performance debug.

## Interface
- `DATA_W`, 32: payload width (instruction or bundled control word).
- `PC_W`, 32: width of the PC and NPC fields.
- `RESET_PC`, 32'h0000_0000: value of `out_pc` and `out_npc` after reset.
- `NOP_WORD`, 32'h0000_0000: payload driven when the stage holds a bubble (MIPS `sll $0,$0,0`).
- `SKID`, 1: 1 adds a skid entry so `in_ready` is a flop output; 0 means single entry with combinational `in_ready`.
- `CNT_W`, 16: stall counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream has a valid entry.
- `in_ready`  out  1  stage accepts the entry this cycle.
- `in_pc`, `in_npc`  in  PC_W  PC and next-PC of the incoming entry.
- `in_data`  in  DATA_W  incoming payload.
- `stall`  in  1  hazard-unit hold; freezes the output entry.
- `flush`  in  1  kill every held entry and insert a bubble.
- `out_valid`  out  1  output entry is valid.
- `out_ready`  in  1  downstream consumes the output entry.
- `out_pc`, `out_npc`  out  PC_W  registered PC and next-PC.
- `out_data`  out  DATA_W  registered payload; `NOP_WORD` when the stage holds a bubble after flush or reset.
- `stall_cnt`  out  CNT_W  saturating count of cycles with `stall`=1 and `out_valid`=1.

## Operation
- The output is consumed when `out_fire = out_valid & out_ready & ~stall`. The input is accepted when `in_fire = in_valid & in_ready`.
- `in_ready` is 0 whenever `flush`=1.
- If SKID=0: `in_ready = ~flush & (~out_valid | out_fire)`.
- If SKID=1: `in_ready = ~flush & ~skid_valid`.
- States (SKID=1):
  - EMPTY: `out_valid`=0, `skid_valid`=0.
  - FULL: `out_valid`=1, `skid_valid`=0.
  - SKIDDED: `out_valid`=1, `skid_valid`=1.
- Transitions:
  - EMPTY: `in_fire` loads the output register and goes to FULL.
  - FULL:
    - `in_fire & out_fire`: replace the output entry and stay in FULL.
    - `in_fire & ~out_fire`: write the input to the skid entry and go to SKIDDED.
    - `~in_fire & out_fire`: go to EMPTY.
  - SKIDDED: `out_fire` moves the skid entry to the output register and goes to FULL. No input is accepted in this state.
- SKID=0 has only EMPTY and FULL, with the same rules minus the skid path.
- Flush has the highest priority over stall, handshake and skid:
  - next cycle: `out_valid`=0, `skid_valid`=0, `out_data`=`NOP_WORD`;
  - `out_pc` and `out_npc` hold their values;
  - no input is accepted during the flush cycle.
- Stall with `flush`=0:
  - the output register and skid entry hold;
  - in SKID=1 FULL, an input may still be accepted into the skid entry.
- A bubble never overwrites `out_pc` or `out_npc`; only `out_data` is forced to `NOP_WORD` when `out_valid` falls due to flush.
- When the stage empties through `out_fire`, `out_data` keeps its last value. Consumers qualify on `out_valid`.
- `stall_cnt` increments when `stall & out_valid`, saturates at all-ones, and is cleared only by reset.

## Timing
- Latency is 1 cycle from `in_fire` to `out_valid` in EMPTY.
- Throughput is 1 entry per cycle when `out_ready`=1 and `stall`=0.
- Reset values: `out_valid`=0, `out_pc`=`out_npc`=`RESET_PC`, `out_data`=`NOP_WORD`, `skid_valid`=0, `stall_cnt`=0.
- `in_ready` after reset is 1.
- Reset is asynchronous: assertion mid-transfer drops `out_valid` immediately, whatever the clock and the other inputs. Release is synchronised externally, and the first edge after release follows the EMPTY rules.
- `flush` and `stall` in the same cycle: flush wins, and `stall_cnt` still counts if `out_valid`=1 that cycle.
- In SKID=1, `in_ready` changes only on the clock edge except for the combinational `flush` term.

## Structure
- Shared package `pipe_pkg`: `MIPS_NOP` constant (32'h0), `RESET_VECTOR`, and a typed state enum `pipe_state_e` {EMPTY, FULL, SKIDDED}.
- One sub-module, `pipe_skid_entry`: a storage slot holding valid, pc, npc and data, instantiated only under `generate if (SKID)`.
- Top level: handshake logic, output register, flush/stall priority and stall counter.

## Test plan
- Reset then stream: after reset, feed PCs 0x0,0x4,0x8 with `out_ready`=1 → outputs appear one cycle later in order; `stall_cnt`=0; `out_data`=0 before the first valid.
- Stall hold: with FULL at PC 0x10, assert `stall` for 3 cycles with `in_valid`=1, SKID=1 → output holds 0x10; PC 0x14 goes to the skid entry; `in_ready`=0 after one cycle; `stall_cnt`=3.
- Drain after stall: release `stall` → output 0x14 next cycle, `in_ready` returns to 1, no entry lost or duplicated.
- Flush in SKIDDED: flush → next cycle `out_valid`=0, `out_data`=0, `out_pc` unchanged, skid entry discarded; `in_ready`=0 during the flush cycle.
- Backpressure, SKID=0: hold `out_ready`=0 while FULL → `in_ready`=0 combinationally; raising `out_ready` accepts a new entry the same cycle.
- Async reset mid-stream with `stall_cnt`=0xFFFF (saturated): pulse `reset_n` low between clock edges → `out_valid`=0 and `stall_cnt`=0 immediately, without waiting for a clock edge.
